// File: rtl/pll_reconf_ctrl_pkg.sv
// Shared definitions for the PLL reconfiguration controller:
// FSM state encoding, ROM layout widths and default timing constants.
// ROM layout: ROM_ADDR = {setting[7:0], word_index[WBW-1:0]}, word 0 first.
package pll_reconf_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD    = 3'd1,
      ST_CAP   = 3'd2,
      ST_WR    = 3'd3,
      ST_WAITW = 3'd4,
      ST_RST   = 3'd5,
      ST_LOCK  = 3'd6
   } state_t;

   // Setting index width; ROM address is SET_W + WBW bits.
   localparam int unsigned SET_W = 8;

   // Shared timer width, wide enough for the longest lock timeout.
   localparam int unsigned TMR_W = 20;

   localparam int unsigned           DEF_RST_CYC = 16;
   localparam logic [TMR_W-1:0]      DEF_LOCK_TO = 20'hFFFFF;

endpackage

// File: rtl/pll_reconf_ctrl_timer.sv
// Loadable down-counter with zero flag. Shared between the PLL reset
// hold time and the lock timeout; the two never run at the same time.
module pll_reconf_ctrl_timer
   import pll_reconf_ctrl_pkg::*;
#(
   parameter int unsigned W = TMR_W
) (
   input  logic         CLK,
   input  logic         RSTX,
   input  logic         LD,
   input  logic         EN,
   input  logic [W-1:0] VAL,
   output logic         ZERO
);

   logic [W-1:0] cnt_q;

   // Load has priority; otherwise count down while enabled, saturating at 0.
   always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
         cnt_q <= '0;
      end else if (LD) begin
         cnt_q <= VAL;
      end else if (EN && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign ZERO = (cnt_q == '0);

endmodule

// File: rtl/pll_reconf_ctrl.sv
// PLL reconfiguration controller. Accepts change requests from the
// button controller, streams NWORD config words from ROM into the PLL
// reconfig port, pulses PLL reset and waits for a stable lock.
// Optional feature macro: PLL_RECONF_LOCK_TIMEOUT_EN (lock timeout + ERR).
module pll_reconf_ctrl
   import pll_reconf_ctrl_pkg::*;
#(
   parameter int unsigned       NWORD   = 4,
   parameter int unsigned       WBW     = 2,
   parameter int unsigned       DW      = 16,
   parameter int unsigned       RST_CYC = DEF_RST_CYC,
   parameter logic [TMR_W-1:0]  LOCK_TO = DEF_LOCK_TO
) (
   input  logic                 CLK,
   input  logic                 RSTX,
   input  logic                 PLL_CHG,
   input  logic [SET_W-1:0]     PLL_ADDR,
   output logic [SET_W+WBW-1:0] ROM_ADDR,
   input  logic [DW-1:0]        ROM_DATA,
   output logic                 RCFG_WE,
   output logic [WBW-1:0]       RCFG_ADDR,
   output logic [DW-1:0]        RCFG_DATA,
   input  logic                 RCFG_BUSY,
   output logic                 PLL_ARESET,
   input  logic                 PLL_LOCKED,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 ERR
);

   localparam logic [TMR_W-1:0] RST_LD   = TMR_W'(RST_CYC - 1);
   localparam logic [TMR_W-1:0] LOCK_LD  = LOCK_TO - 1'b1;
   localparam logic [WBW-1:0]   LAST_IDX = WBW'(NWORD - 1);

   state_t             state_q, state_d;
   logic [SET_W-1:0]   set_q;
   logic [SET_W-1:0]   pend_addr_q;
   logic [SET_W-1:0]   new_set;
   logic               pend_q;
   logic [WBW-1:0]     idx_q;
   logic [WBW-1:0]     idx_nx;
   logic               accept, restart, advance, finish, timeout, lock_ok;
   logic               lk_m, lk_s, lk_run;
   logic               tmr_ld, tmr_en, tmr_zero;
   logic [TMR_W-1:0]   tmr_val;

   assign idx_nx  = idx_q + 1'b1;
   assign lock_ok = (state_q == ST_LOCK) && lk_s && lk_run;
   assign tmr_en  = (state_q == ST_RST) || (state_q == ST_LOCK);

   pll_reconf_ctrl_timer #(
      .W (TMR_W)
   ) u_timer (
      .CLK  (CLK),
      .RSTX (RSTX),
      .LD   (tmr_ld),
      .EN   (tmr_en),
      .VAL  (tmr_val),
      .ZERO (tmr_zero)
   );

   // State register.
   always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and per-cycle control decode.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      restart = 1'b0;
      advance = 1'b0;
      finish  = 1'b0;
      timeout = 1'b0;
      tmr_ld  = 1'b0;
      tmr_val = RST_LD;
      // A request in the finishing cycle wins over an older pending one.
      new_set = PLL_CHG ? PLL_ADDR : pend_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (PLL_CHG) begin
               accept  = 1'b1;
               state_d = ST_RD;
            end
         end
         ST_RD:  state_d = ST_CAP;
         ST_CAP: state_d = ST_WR;
         ST_WR:  state_d = ST_WAITW;
         ST_WAITW: begin
            if (!RCFG_BUSY) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_RST;
                  tmr_ld  = 1'b1;
                  tmr_val = RST_LD;
               end else begin
                  advance = 1'b1;
                  state_d = ST_RD;
               end
            end
         end
         ST_RST: begin
            if (tmr_zero) begin
               state_d = ST_LOCK;
               tmr_ld  = 1'b1;
               tmr_val = LOCK_LD;
            end
         end
         ST_LOCK: begin
`ifdef PLL_RECONF_LOCK_TIMEOUT_EN
            timeout = tmr_zero && !lock_ok;
`endif
            finish = lock_ok || timeout;
            if (finish) begin
               if (pend_q || PLL_CHG) begin
                  restart = 1'b1;
                  state_d = ST_RD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Setting/word index, ROM address and captured config word.
   always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
         set_q     <= '0;
         idx_q     <= '0;
         ROM_ADDR  <= '0;
         RCFG_DATA <= '0;
      end else begin
         if (accept || restart) begin
            set_q    <= new_set;
            idx_q    <= '0;
            ROM_ADDR <= {new_set, {WBW{1'b0}}};
         end else if (advance) begin
            idx_q    <= idx_nx;
            ROM_ADDR <= {set_q, idx_nx};
         end
         if (state_q == ST_CAP) begin
            RCFG_DATA <= ROM_DATA;
         end
      end
   end

   // Pending request store; last address wins, cleared on restart.
   always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
      end else if (restart) begin
         pend_q      <= 1'b0;
      end else if (PLL_CHG && (state_q != ST_IDLE)) begin
         pend_q      <= 1'b1;
         pend_addr_q <= PLL_ADDR;
      end
   end

   // Two-flop lock synchroniser plus "previous sample high while in LOCK".
   always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
         lk_m   <= 1'b0;
         lk_s   <= 1'b0;
         lk_run <= 1'b0;
      end else begin
         lk_m   <= PLL_LOCKED;
         lk_s   <= lk_m;
         lk_run <= (state_q == ST_LOCK) && lk_s;
      end
   end

`ifdef PLL_RECONF_LOCK_TIMEOUT_EN
   // Sticky lock-timeout flag, cleared when the next request starts.
   always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
         ERR <= 1'b0;
      end else if (timeout) begin
         ERR <= 1'b1;
      end else if (accept || restart) begin
         ERR <= 1'b0;
      end
   end
`else
   assign ERR = 1'b0;
`endif

   assign BUSY       = (state_q != ST_IDLE);
   assign RCFG_WE    = (state_q == ST_WR);
   assign RCFG_ADDR  = idx_q;
   assign PLL_ARESET = (state_q == ST_RST);
   assign DONE       = finish;

endmodule

// File: tb/tb_pll_reconf_ctrl.sv
// Directed bench for pll_reconf_ctrl: table of expected outputs per
// scenario/cycle, plus hand-written reset, lock-glitch and no-lock cases.
// Cycle 0 of each scenario window is the cycle in which PLL_CHG is high.
module tb_pll_reconf_ctrl;

   localparam int S_WE = 0, S_RA = 1, S_RD = 2, S_ROMA = 3;
   localparam int S_BUSY = 4, S_ARES = 5, S_DONE = 6, S_ERR = 7;

   logic        CLK = 1'b0;
   logic        RSTX = 1'b0;
   logic        PLL_CHG = 1'b0;
   logic [7:0]  PLL_ADDR = 8'h00;
   logic [9:0]  ROM_ADDR;
   logic [15:0] ROM_DATA;
   logic        RCFG_WE;
   logic [1:0]  RCFG_ADDR;
   logic [15:0] RCFG_DATA;
   logic        RCFG_BUSY = 1'b0;
   logic        PLL_ARESET;
   logic        PLL_LOCKED = 1'b1;
   logic        BUSY;
   logic        DONE;
   logic        ERR;

   typedef struct {
      int          scn;
      int          cyc;
      int          sig;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      int         scn;
      int         cyc;
      logic [7:0] addr;
   } req_t;

   vec_t tbl[$];
   req_t reqs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic       obs_busy [0:255];
   logic       obs_done [0:255];
   logic       obs_we   [0:255];
   logic       obs_ares [0:255];
   logic       obs_err  [0:255];
   logic [9:0] obs_roma [0:255];

   pll_reconf_ctrl #(
      .NWORD   (4),
      .WBW     (2),
      .DW      (16),
      .RST_CYC (16),
      .LOCK_TO (20'd100)
   ) dut (
      .CLK        (CLK),
      .RSTX       (RSTX),
      .PLL_CHG    (PLL_CHG),
      .PLL_ADDR   (PLL_ADDR),
      .ROM_ADDR   (ROM_ADDR),
      .ROM_DATA   (ROM_DATA),
      .RCFG_WE    (RCFG_WE),
      .RCFG_ADDR  (RCFG_ADDR),
      .RCFG_DATA  (RCFG_DATA),
      .RCFG_BUSY  (RCFG_BUSY),
      .PLL_ARESET (PLL_ARESET),
      .PLL_LOCKED (PLL_LOCKED),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .ERR        (ERR)
   );

   always #5 CLK = ~CLK;

   function automatic logic [15:0] rom_word(input logic [9:0] a);
      return {a[5:0], a} ^ 16'h5A3C;
   endfunction

   // Synchronous ROM: data one cycle after address.
   always @(posedge CLK) ROM_DATA <= rom_word(ROM_ADDR);

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] get_sig(input int s);
      case (s)
         S_WE:    return {31'd0, RCFG_WE};
         S_RA:    return {30'd0, RCFG_ADDR};
         S_RD:    return {16'd0, RCFG_DATA};
         S_ROMA:  return {22'd0, ROM_ADDR};
         S_BUSY:  return {31'd0, BUSY};
         S_ARES:  return {31'd0, PLL_ARESET};
         S_DONE:  return {31'd0, DONE};
         S_ERR:   return {31'd0, ERR};
         default: return 32'd0;
      endcase
   endfunction

   function automatic string sig_name(input int s);
      case (s)
         S_WE:    return "RCFG_WE";
         S_RA:    return "RCFG_ADDR";
         S_RD:    return "RCFG_DATA";
         S_ROMA:  return "ROM_ADDR";
         S_BUSY:  return "BUSY";
         S_ARES:  return "PLL_ARESET";
         S_DONE:  return "DONE";
         S_ERR:   return "ERR";
         default: return "?";
      endcase
   endfunction

   function automatic logic lock_stim(input int scn, input int n);
      case (scn)
         6:       return (n == 40) || (n >= 50);
         7:       return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input int scn, input int cyc, input int sig, input logic [31:0] exp);
      tbl.push_back('{scn, cyc, sig, exp});
   endtask

   // Expected trace of one undisturbed sequence whose request cycle is t0.
   task automatic add_seq(input int scn, input int t0, input logic [7:0] base);
      for (int k = 0; k < 4; k++) begin
         logic [9:0] a;
         a = {base, 2'(k)};
         add(scn, t0 + 1 + 4*k, S_ROMA, {22'd0, a});
         add(scn, t0 + 2 + 4*k, S_WE,   32'd0);
         add(scn, t0 + 3 + 4*k, S_WE,   32'd1);
         add(scn, t0 + 3 + 4*k, S_RA,   32'(k));
         add(scn, t0 + 3 + 4*k, S_RD,   {16'd0, rom_word(a)});
      end
      add(scn, t0 + 16, S_ARES, 32'd0);
      add(scn, t0 + 17, S_ARES, 32'd1);
      add(scn, t0 + 32, S_ARES, 32'd1);
      add(scn, t0 + 33, S_ARES, 32'd0);
      add(scn, t0 + 33, S_DONE, 32'd0);
      add(scn, t0 + 34, S_DONE, 32'd1);
   endtask

   task automatic run_window(input int ncyc, input int scn);
      for (int n = 0; n < ncyc; n++) begin
         PLL_CHG = 1'b0;
         foreach (reqs[i]) begin
            if (reqs[i].scn == scn && reqs[i].cyc == n) begin
               PLL_CHG  = 1'b1;
               PLL_ADDR = reqs[i].addr;
            end
         end
         RCFG_BUSY  = (scn == 2 && n >= 8 && n <= 17) || (scn == 4 && n >= 11);
         PLL_LOCKED = lock_stim(scn, n);
         @(negedge CLK);
         obs_busy[n] = BUSY;
         obs_done[n] = DONE;
         obs_we[n]   = RCFG_WE;
         obs_ares[n] = PLL_ARESET;
         obs_err[n]  = ERR;
         obs_roma[n] = ROM_ADDR;
         foreach (tbl[i]) begin
            if (tbl[i].scn == scn && tbl[i].cyc == n) begin
               chk($sformatf("s%0d_c%0d_%s", scn, n, sig_name(tbl[i].sig)),
                   get_sig(tbl[i].sig), tbl[i].exp);
            end
         end
         @(posedge CLK);
         #1;
      end
      PLL_CHG = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_BUSY"},       {31'd0, BUSY},       32'd0);
      chk({tag, "_DONE"},       {31'd0, DONE},       32'd0);
      chk({tag, "_ERR"},        {31'd0, ERR},        32'd0);
      chk({tag, "_RCFG_WE"},    {31'd0, RCFG_WE},    32'd0);
      chk({tag, "_PLL_ARESET"}, {31'd0, PLL_ARESET}, 32'd0);
      chk({tag, "_RCFG_ADDR"},  {30'd0, RCFG_ADDR},  32'd0);
      chk({tag, "_RCFG_DATA"},  {16'd0, RCFG_DATA},  32'd0);
      chk({tag, "_ROM_ADDR"},   {22'd0, ROM_ADDR},   32'd0);
   endtask

   function automatic int count_bits(input int sel, input int lo, input int hi);
      int c;
      c = 0;
      for (int n = lo; n <= hi; n++) begin
         case (sel)
            0: c += int'(obs_we[n]);
            1: c += int'(obs_ares[n]);
            2: c += int'(obs_done[n]);
            3: c += int'(!obs_busy[n]);
            default: c += 0;
         endcase
      end
      return c;
   endfunction

   initial begin
      int bad_fetch;

      // Scenario 1: plain request, setting 0x05.
      reqs.push_back('{1, 0, 8'h05});
      add_seq(1, 0, 8'h05);
      add(1, 1,  S_BUSY, 32'd1);
      add(1, 34, S_BUSY, 32'd1);
      add(1, 35, S_BUSY, 32'd0);
      add(1, 35, S_DONE, 32'd0);

      // Scenario 2: RCFG_BUSY held 10 cycles after the 2nd write.
      reqs.push_back('{2, 0, 8'h0A});
      add(2, 7,  S_WE,   32'd1);
      add(2, 11, S_WE,   32'd0);
      add(2, 18, S_ROMA, 32'h029);
      add(2, 19, S_ROMA, 32'h02A);
      add(2, 20, S_WE,   32'd0);
      add(2, 21, S_WE,   32'd1);
      add(2, 21, S_RA,   32'd2);
      add(2, 21, S_RD,   {16'd0, rom_word(10'h02A)});
      add(2, 25, S_WE,   32'd1);
      add(2, 25, S_RA,   32'd3);
      add(2, 44, S_DONE, 32'd1);
      add(2, 45, S_BUSY, 32'd0);

      // Scenario 3: two requests while busy, last one (0x07) wins.
      reqs.push_back('{3, 0, 8'h01});
      reqs.push_back('{3, 5, 8'h03});
      reqs.push_back('{3, 9, 8'h07});
      add_seq(3, 0, 8'h01);
      add_seq(3, 34, 8'h07);
      add(3, 69, S_BUSY, 32'd0);

      // Scenario 4/5: reset in WAITW of word 2, then a clean sequence.
      reqs.push_back('{4, 0, 8'h05});
      add(4, 11, S_WE, 32'd1);
      add(4, 11, S_RA, 32'd2);
      reqs.push_back('{5, 0, 8'h02});
      add_seq(5, 0, 8'h02);
      add(5, 35, S_BUSY, 32'd0);

      // Scenario 6: lock glitch at cycle 40, stable lock from 50.
      reqs.push_back('{6, 0, 8'h06});
      add(6, 33, S_BUSY, 32'd1);
      add(6, 43, S_DONE, 32'd0);
      add(6, 53, S_DONE, 32'd1);
      add(6, 54, S_BUSY, 32'd0);

      // Scenario 7: lock never arrives.
      reqs.push_back('{7, 0, 8'h09});

      // Reset state.
      repeat (2) @(negedge CLK);
      check_all_zero("reset");
      @(posedge CLK);
      #1;
      RSTX = 1'b1;
      @(posedge CLK);
      #1;

      run_window(40, 1);
      chk("s1_we_count",    32'(count_bits(0, 0, 39)), 32'd4);
      chk("s1_areset_cyc",  32'(count_bits(1, 0, 39)), 32'd16);
      chk("s1_done_count",  32'(count_bits(2, 0, 39)), 32'd1);

      run_window(50, 2);
      chk("s2_we_count",    32'(count_bits(0, 0, 49)), 32'd4);
      chk("s2_done_count",  32'(count_bits(2, 0, 49)), 32'd1);

      run_window(75, 3);
      chk("s3_busy_gap",    32'(count_bits(3, 1, 68)), 32'd0);
      chk("s3_done_count",  32'(count_bits(2, 0, 74)), 32'd2);
      chk("s3_we_count",    32'(count_bits(0, 0, 74)), 32'd8);
      bad_fetch = 0;
      for (int n = 0; n < 75; n++) begin
         if (obs_roma[n][9:2] == 8'h03) bad_fetch++;
      end
      chk("s3_fetch_0x03",  32'(bad_fetch), 32'd0);

      run_window(12, 4);
      @(negedge CLK);
      chk("s4_busy_pre_rst", {31'd0, BUSY}, 32'd1);
      RSTX = 1'b0;
      #1;
      check_all_zero("s4_midrst");
      @(posedge CLK);
      #1;
      RCFG_BUSY = 1'b0;
      RSTX      = 1'b1;
      @(posedge CLK);
      #1;
      run_window(40, 5);
      chk("s5_we_count",    32'(count_bits(0, 0, 39)), 32'd4);
      chk("s5_done_count",  32'(count_bits(2, 0, 39)), 32'd1);

      run_window(60, 6);
      chk("s6_no_early_done", 32'(count_bits(2, 0, 52)), 32'd0);
      chk("s6_done_count",    32'(count_bits(2, 0, 59)), 32'd1);

      run_window(200, 7);
`ifdef PLL_RECONF_LOCK_TIMEOUT_EN
      chk("s7_done_c131", {31'd0, obs_done[131]}, 32'd0);
      chk("s7_done_c132", {31'd0, obs_done[132]}, 32'd1);
      chk("s7_err_c132",  {31'd0, obs_err[132]},  32'd0);
      chk("s7_err_c133",  {31'd0, obs_err[133]},  32'd1);
      chk("s7_busy_c133", {31'd0, obs_busy[133]}, 32'd0);
      reqs.push_back('{8, 0, 8'h09});
      add(8, 0, S_ERR,  32'd1);
      add(8, 1, S_ERR,  32'd0);
      add(8, 1, S_BUSY, 32'd1);
      run_window(4, 8);
`else
      chk("s7_busy_c150",  {31'd0, obs_busy[150]}, 32'd1);
      chk("s7_busy_c199",  {31'd0, obs_busy[199]}, 32'd1);
      chk("s7_err_c199",   {31'd0, obs_err[199]},  32'd0);
      chk("s7_done_count", 32'(count_bits(2, 0, 199)), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
